// File: rtl/ez8_loader_pkg.sv
// Shared definitions for the ez8 serial boot loader.
//   state_t    : packet FSM states
//   rx_state_t : UART receiver states
//   SYNC_BYTE  : packet start marker
//   baud_div() : clocks per UART bit (truncating integer divide)
package ez8_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/ez8_uart_rx.sv
// 8N1 UART receiver for the ez8 boot loader.
//   clk, reset_n : system clock, async active-low reset
//   uart_rx      : asynchronous serial input, idle high
//   rx_valid     : 1-cycle pulse after a stop bit sampled high
//   rx_data      : received byte, valid with rx_valid
//   rx_ferr      : 1-cycle pulse after a stop bit sampled low (byte dropped)
module ez8_uart_rx
  import ez8_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int unsigned DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF = (DIV / 2 > 0) ? DIV / 2 : 1;
  localparam int unsigned CW   = $clog2(DIV + 1);

  rx_state_t     state, next;
  logic          meta, sync, prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  assign tick    = (cnt == '0);
  assign rx_data = shreg;

  always_comb begin
    next = state;
    case (state)
      RX_IDLE:  if (prev && !sync) next = RX_START;
      // A start bit that is high again at mid-bit is treated as a glitch.
      RX_START: if (tick) next = sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) next = RX_STOP;
      RX_STOP:  if (tick) next = RX_IDLE;
      default:  next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RX_IDLE;
      meta     <= 1'b1;
      sync     <= 1'b1;
      prev     <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      state    <= next;
      meta     <= uart_rx;
      sync     <= meta;
      prev     <= sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (state == RX_IDLE) begin
        // Preload half a bit so the first tick lands mid start bit.
        cnt     <= CW'(HALF - 1);
        bit_idx <= '0;
      end else begin
        cnt <= tick ? CW'(DIV - 1) : cnt - 1'b1;
        if (tick && state == RX_DATA) begin
          shreg   <= {sync, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        if (tick && state == RX_STOP) begin
          rx_valid <= sync;
          rx_ferr  <= !sync;
        end
      end
    end
  end

endmodule

// File: rtl/ez8_uart_loader.sv
// Serial boot loader: receives 55 LEN_HI LEN_LO {HI LO}*N over UART, writes
// words into ez8_cpu instruction memory, holds the CPU paused meanwhile and
// pulses cpu_reset on a successful load.
// Optional build macro LOADER_CHECKSUM_EN: a trailing byte equal to the 8-bit
// sum of LEN_HI, LEN_LO and all data bytes must follow the image.
//   clk, reset_n     : system clock, async active-low reset
//   uart_rx          : serial input, 8N1, idle high
//   instr_writeaddr  : word index mod 2^ADDR_WIDTH
//   instr_writedata  : {DATA_HI, DATA_LO}
//   instr_write_en   : 1-cycle write strobe
//   pause            : CPU stall while a packet is in progress
//   cpu_reset        : 1-cycle pulse after a successful load
//   loading          : FSM not in IDLE
//   error            : sticky framing/timeout/checksum error, cleared by sync
module ez8_uart_loader
  import ez8_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned BAUD           = 115200,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [DATA_WIDTH-1:0] instr_writedata,
  output logic                  instr_write_en,
  output logic                  pause,
  output logic                  cpu_reset,
  output logic                  loading,
  output logic                  error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHECK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t                state, next;
  logic                  rx_valid, rx_ferr;
  logic [7:0]            rx_data;
  logic [7:0]            len_hi, data_hi, data_lo;
  logic [15:0]           remaining;
  logic [ADDR_WIDTH-1:0] idx;
  logic [TW-1:0]         timer;
  logic                  expire, sync_seen, chk_fail;

  ez8_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_rx  (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  assign instr_writeaddr = idx;
  assign instr_writedata = DATA_WIDTH'({data_hi, data_lo});
  assign instr_write_en  = (state == WRITE);
  assign cpu_reset       = (state == DONE);
  assign loading         = (state != IDLE);
  assign pause           = (state != IDLE);

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire    = (state != IDLE) && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign sync_seen = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign chk_fail = (state == CHECK) && rx_valid && (rx_data != csum);
`else
  assign chk_fail = 1'b0;
`endif

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (sync_seen) next = LEN_HI;
      LEN_HI:  if (rx_valid) next = LEN_LO;
      LEN_LO:  if (rx_valid) next = ({len_hi, rx_data} == 16'd0) ? AFTER_DATA : DATA_HI;
      DATA_HI: if (rx_valid) next = DATA_LO;
      DATA_LO: if (rx_valid) next = WRITE;
      WRITE:   next = (remaining == 16'd1) ? AFTER_DATA : DATA_HI;
      CHECK:   if (rx_valid) next = chk_fail ? IDLE : DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (rx_ferr || expire) next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_hi    <= '0;
      data_hi   <= '0;
      data_lo   <= '0;
      remaining <= '0;
      idx       <= '0;
      timer     <= '0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      if (state == IDLE || rx_valid) timer <= '0;
      else if (!expire)              timer <= timer + 1'b1;

      if (rx_ferr || expire || chk_fail) error <= 1'b1;
      else if (sync_seen)                error <= 1'b0;

      if (sync_seen) idx <= '0;
      if (rx_valid) begin
        case (state)
          LEN_HI:  len_hi    <= rx_data;
          LEN_LO:  remaining <= {len_hi, rx_data};
          DATA_HI: data_hi   <= rx_data;
          DATA_LO: data_lo   <= rx_data;
          default: ;
        endcase
      end
      if (state == WRITE) begin
        idx       <= idx + 1'b1;
        remaining <= remaining - 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (sync_seen) csum <= '0;
      else if (rx_valid && (state == LEN_HI || state == LEN_LO ||
                            state == DATA_HI || state == DATA_LO))
        csum <= csum + rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_ez8_uart_loader.sv
module tb_ez8_uart_loader;

  localparam int unsigned DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        uart_rx;
  logic [11:0] instr_writeaddr;
  logic [15:0] instr_writedata;
  logic        instr_write_en, pause, cpu_reset, loading, error;

  int          tests = 0;
  int          fails = 0;
  int          rst_cnt = 0;
  int          rst0;
  logic        saw_loading, saw_pause, prev_rst;
  logic [27:0] exp_wr[$];
  logic [15:0] words[$];
  logic [7:0]  sum;

  always #5 clk = ~clk;

  ez8_uart_loader #(
    .CLK_FREQ(1000000), .BAUD(100000), .ADDR_WIDTH(12),
    .DATA_WIDTH(16), .TIMEOUT_CYCLES(500)
  ) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .instr_writeaddr(instr_writeaddr), .instr_writedata(instr_writedata),
    .instr_write_en(instr_write_en), .pause(pause), .cpu_reset(cpu_reset),
    .loading(loading), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every write is popped against the queued expectation.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rst <= 1'b0;
    end else begin
      if (instr_write_en) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 32'(exp_wr.size()), 32'd1);
        end else begin
          logic [27:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(instr_writeaddr), 32'(e[27:16]));
          check("wr_data", 32'(instr_writedata), 32'(e[15:0]));
          check("wr_pause", 32'(pause), 32'd1);
        end
      end
      if (prev_rst) check("pause_after_done", 32'(pause), 32'd0);
      if (cpu_reset) rst_cnt++;
      if (loading) saw_loading = 1'b1;
      if (pause) saw_pause = 1'b1;
      prev_rst <= cpu_reset;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(DIV);
    end
    uart_rx = stop;
    idle(DIV);
    uart_rx = 1'b1;
    idle(DIV);
  endtask

  // Sends sync, length and the words[] image, queueing expected writes.
  task automatic send_packet(input logic [15:0] n);
    sum = n[15:8] + n[7:0];
    send_byte(8'h55, 1'b1);
    send_byte(n[15:8], 1'b1);
    send_byte(n[7:0], 1'b1);
    foreach (words[i]) begin
      logic [11:0] a;
      a = 12'(i);
      exp_wr.push_back({a, words[i]});
      sum = sum + words[i][15:8] + words[i][7:0];
      send_byte(words[i][15:8], 1'b1);
      send_byte(words[i][7:0], 1'b1);
    end
  endtask

  task automatic send_trailer(input logic bad);
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad ? sum + 8'd1 : sum, 1'b1);
`else
    if (bad) $display("[TB] corrupt trailer ignored: checksum not built in");
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    uart_rx = 1'b1;
    idle(5);
    check("rst_we",      32'(instr_write_en),  32'd0);
    check("rst_addr",    32'(instr_writeaddr), 32'd0);
    check("rst_data",    32'(instr_writedata), 32'd0);
    check("rst_pause",   32'(pause),           32'd0);
    check("rst_cpu_rst", 32'(cpu_reset),       32'd0);
    check("rst_loading", 32'(loading),         32'd0);
    check("rst_error",   32'(error),           32'd0);
    reset_n = 1'b1;
    idle(5);

    // Two-word image.
    rst0 = rst_cnt;
    words = {16'h1234, 16'hABCD};
    send_packet(16'd2);
    send_trailer(1'b0);
    idle(30);
    check("t1_cpu_rst", 32'(rst_cnt - rst0), 32'd1);
    check("t1_error",   32'(error),          32'd0);
    check("t1_pause",   32'(pause),          32'd0);
    check("t1_drain",   32'(exp_wr.size()),  32'd0);

    // Non-sync bytes in IDLE are ignored.
    saw_loading = 1'b0;
    saw_pause   = 1'b0;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(30);
    check("t2_loading", 32'(saw_loading), 32'd0);
    check("t2_pause",   32'(saw_pause),   32'd0);

    // Empty image.
    rst0 = rst_cnt;
    words.delete();
    send_packet(16'd0);
    send_trailer(1'b0);
    idle(30);
    check("t3_cpu_rst", 32'(rst_cnt - rst0), 32'd1);
    check("t3_pause",   32'(pause),          32'd0);

    // Stall inside a packet -> timeout.
    rst0 = rst_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    check("t4_loading_mid", 32'(loading), 32'd1);
    idle(600);
    check("t4_error",   32'(error),          32'd1);
    check("t4_pause",   32'(pause),          32'd0);
    check("t4_loading", 32'(loading),        32'd0);
    check("t4_cpu_rst", 32'(rst_cnt - rst0), 32'd0);

    // Framing error after sync, then recovery.
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b0);
    idle(20);
    check("t5_error",   32'(error),   32'd1);
    check("t5_loading", 32'(loading), 32'd0);
    rst0 = rst_cnt;
    words.delete();
    send_packet(16'd0);
    send_trailer(1'b0);
    idle(30);
    check("t5_clear",   32'(error),          32'd0);
    check("t5_cpu_rst", 32'(rst_cnt - rst0), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 00+01+12+34 = 47 is the valid trailer.
    rst0 = rst_cnt;
    words = {16'h1234};
    send_packet(16'd1);
    check("t6_sum_model", 32'(sum), 32'h47);
    send_trailer(1'b0);
    idle(30);
    check("t6_ok_rst",   32'(rst_cnt - rst0), 32'd1);
    check("t6_ok_error", 32'(error),          32'd0);
    rst0 = rst_cnt;
    send_packet(16'd1);
    send_trailer(1'b1);
    idle(30);
    check("t6_bad_rst",   32'(rst_cnt - rst0), 32'd0);
    check("t6_bad_error", 32'(error),          32'd1);
    check("t6_bad_pause", 32'(pause),          32'd0);
`endif

    // Async reset while waiting for DATA_LO.
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    check("t7_loading_mid", 32'(loading), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t7_we",      32'(instr_write_en),  32'd0);
    check("t7_addr",    32'(instr_writeaddr), 32'd0);
    check("t7_data",    32'(instr_writedata), 32'd0);
    check("t7_pause",   32'(pause),           32'd0);
    check("t7_loading", 32'(loading),         32'd0);
    check("t7_error",   32'(error),           32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    rst0 = rst_cnt;
    words = {16'hBEEF};
    send_packet(16'd1);
    send_trailer(1'b0);
    idle(30);
    check("t7_cpu_rst", 32'(rst_cnt - rst0), 32'd1);
    check("t7_drain",   32'(exp_wr.size()),  32'd0);
    check("t7_error2",  32'(error),          32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
